spi_multi_request_data: RTL and testbench
=========================================

// Module: spi_multi_request_data
// PURPOSE
//  Parametrised multi-slave SPI receive master. One start_transfer pulse runs a sweep: each enabled
//  slave is selected in ascending order and one FRAME_BITS frame is read from it, split into
//  sin_index (MSBs) and uart_id (LSBs). Each frame is published with data_valid, the slave number
//  and an ID-consistency flag. Sits between the controller's sample tick and the sine/UART dispatch logic.
// PARAMETERS
//  N_SLAVES    3   number of SPI slaves (1..8)
//  INDEX_BITS  12  sin_index width (frame MSBs)
//  ID_BITS     4   uart_id width (frame LSBs); FRAME_BITS = INDEX_BITS+ID_BITS
//  CLK_DIV     4   clk cycles per SCLK half-period (>=1)
//  CS_SETUP    2   clk cycles from cs_n low to first SCLK edge (>=1)
//  CS_HOLD     2   clk cycles from last SCLK edge to cs_n high (>=1)
//  CPOL        0   SCLK idle level; CPHA fixed 0: sample on leading edge, slave shifts on trailing edge
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high
//  start_transfer in   1          sweep request pulse
//  slave_en       in   N_SLAVES   enable mask, captured at sweep start
//  miso           in   N_SLAVES   per-slave MISO
//  spi_clk        out  N_SLAVES   per-slave SCLK; only the selected bit toggles
//  cs_n           out  N_SLAVES   per-slave chip select, active low
//  busy           out  1          sweep in progress
//  data_valid     out  1          1-cycle pulse per received frame
//  slave_sel      out  $clog2(N_SLAVES) (min 1)  slave of current/last frame
//  sin_index      out  INDEX_BITS frame[FRAME_BITS-1:ID_BITS], MSB first on wire
//  uart_id        out  ID_BITS    frame[ID_BITS-1:0]
//  id_mismatch    out  1          uart_id != slave_sel, valid with data_valid
//  sweep_done     out  1          1-cycle pulse at end of sweep
// BEHAVIOUR
//  Reset, applied in any state: state=IDLE; cs_n all 1; spi_clk all CPOL; busy, data_valid,
//  sweep_done, id_mismatch = 0; slave_sel, sin_index, uart_id = 0. Any frame in flight is dropped.
//  FSM:
//   IDLE   -> SCAN on start_transfer; mask <= slave_en; busy <= 1.
//   SCAN   -> SETUP for lowest set mask bit. If the mask is empty: sweep_done pulse, busy <= 0, go to IDLE.
//   SETUP  cs_n[sel] low for CS_SETUP cycles -> SHIFT.
//   SHIFT  FRAME_BITS SCLK periods, each 2*CLK_DIV clks. Leading edge: shift miso[sel] into the LSB of shreg.
//   HOLD   SCLK at CPOL for CS_HOLD cycles; cs_n[sel] high at exit -> PUBLISH.
//   PUBLISH  register sin_index, uart_id, slave_sel and id_mismatch; data_valid=1 for one cycle;
//            clear mask[sel] -> SCAN.
//  Outputs hold their values until the next PUBLISH.
//  Per-frame latency, cs_n fall to data_valid: CS_SETUP + 2*CLK_DIV*FRAME_BITS + CS_HOLD + 1 clk.
//  After PUBLISH, the next cs_n fall occurs 2 cycles later (SCAN, SETUP entry). At most one cs_n is low at any time.
//  start_transfer while busy is ignored; no queuing. slave_en changes mid-sweep are ignored.
//  Last frame: data_valid, then 1 cycle later sweep_done. busy falls in the same cycle as sweep_done.
//  id_mismatch compares uart_id, zero-extended, against slave_sel. It is informational only; data is still published.
// STRUCTURE
//  spi_pkg: FSM state enum (IDLE, SCAN, SETUP, SHIFT, HOLD, PUBLISH) and frame field width
//   localparams, shared with the future TX/duplex master.
//  Sub-module spi_sclk_gen: CLK_DIV counter plus half-period toggle, with inputs en and cpol and
//   outputs sclk, lead_stb and trail_stb. Top level holds the FSM, mask/priority encoder,
//   bit counter and shift register.
// TESTING (N_SLAVES=3, CLK_DIV=2, CS_SETUP=CS_HOLD=2, CPOL=0, per-slave SPI model)
//  T1 slave_en=3'b111; models return 16'hABC0, 16'h1231, 16'hFFF2 -> three data_valid pulses:
//     (sel 0, 0xABC, 0), (sel 1, 0x123, 1), (sel 2, 0xFFF, 2). id_mismatch=0 on all;
//     sweep_done 1 cycle after the third pulse.
//  T2 Timing: cs_n fall to data_valid = 2+64+2+1 = 69 clks. SCLK low-high 2/2 clks, 16 rising edges;
//     no SCLK edge while cs_n is high.
//  T3 slave_en=3'b101; slave 2 returns 16'h5551 -> frames from sel 0 and 2 only;
//     second frame has id_mismatch=1; cs_n[1] stays high throughout.
//  T4 slave_en=0 -> sweep_done 2 cycles after start_transfer, no data_valid, busy high for 1 cycle only.
//  T5 start_transfer re-pulsed mid-sweep -> ignored: exactly one sweep, one sweep_done.
//  T6 reset asserted during SHIFT of slave 1 -> next cycle: all cs_n=1, spi_clk=0, busy=0, outputs 0;
//     a fresh start then completes a normal sweep.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master family: FSM states, default frame field widths
// and the select-width helper.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SETUP,
      SHIFT,
      HOLD,
      PUBLISH
   } spi_state_t;

   localparam int DEF_INDEX_BITS = 12;
   localparam int DEF_ID_BITS    = 4;

   // A single slave still needs a one-bit select bus.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles every CLK_DIV clocks while enabled and flags the edge about to occur.
// The first toggle happens in the first enabled cycle, so the caller enables one cycle early.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic srst,
   input  logic en,
   input  logic cpol,
   output logic sclk,
   output logic lead_stb,
   output logic trail_stb
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt_reg;
   logic             sclk_reg;
   logic             tick;

   assign tick      = en && (cnt_reg == CNT_W'(CLK_DIV - 1));
   assign lead_stb  = tick && (sclk_reg == cpol);
   assign trail_stb = tick && (sclk_reg != cpol);
   assign sclk      = sclk_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_reg  <= CNT_W'(CLK_DIV - 1);
         sclk_reg <= cpol;
      end else if (!en) begin
         cnt_reg  <= CNT_W'(CLK_DIV - 1);
         sclk_reg <= cpol;
      end else if (tick) begin
         cnt_reg  <= '0;
         sclk_reg <= ~sclk_reg;
      end else begin
         cnt_reg  <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/spi_multi_request_data.sv
// Multi-slave SPI receive master: one start sweeps every enabled slave in ascending order,
// reads one frame each and publishes it as sin_index/uart_id with an ID-consistency flag.
module spi_multi_request_data
   import spi_pkg::*;
#(
   parameter int N_SLAVES   = 3,
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int ID_BITS    = DEF_ID_BITS,
   parameter int CLK_DIV    = 4,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2,
   parameter bit CPOL       = 1'b0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start_transfer,
   input  logic [N_SLAVES-1:0]              slave_en,
   input  logic [N_SLAVES-1:0]              miso,
   output logic [N_SLAVES-1:0]              spi_clk,
   output logic [N_SLAVES-1:0]              cs_n,
   output logic                             busy,
   output logic                             data_valid,
   output logic [sel_width(N_SLAVES)-1:0]   slave_sel,
   output logic [INDEX_BITS-1:0]            sin_index,
   output logic [ID_BITS-1:0]               uart_id,
   output logic                             id_mismatch,
   output logic                             sweep_done
);

   localparam int SEL_W      = sel_width(N_SLAVES);
   localparam int FRAME_BITS = INDEX_BITS + ID_BITS;
   localparam int SHIFT_CYC  = 2 * CLK_DIV * FRAME_BITS;
   localparam int TMR_W      = $clog2(SHIFT_CYC + CS_SETUP + CS_HOLD + 1);
   localparam int BIT_W      = $clog2(FRAME_BITS + 1);

   spi_state_t              state_reg, state_next;
   logic [N_SLAVES-1:0]     mask_reg;
   logic [SEL_W-1:0]        cur_sel_reg;
   logic [SEL_W-1:0]        lowest_sel;
   logic [TMR_W-1:0]        tmr_reg;
   logic [BIT_W-1:0]        bit_cnt_reg;
   logic [FRAME_BITS-1:0]   shreg_reg;
   logic [N_SLAVES-1:0]     cs_n_reg;
   logic                    busy_reg;
   logic                    data_valid_reg;
   logic                    sweep_done_reg;
   logic [SEL_W-1:0]        slave_sel_reg;
   logic [INDEX_BITS-1:0]   sin_index_reg;
   logic [ID_BITS-1:0]      uart_id_reg;
   logic                    id_mismatch_reg;
   logic                    tmr_zero;
   logic                    gen_en;
   logic                    sclk;
   logic                    lead_stb;
   logic                    trail_stb;

   assign tmr_zero = (tmr_reg == '0);
   // Enabling in the last SETUP cycle puts the first leading edge exactly CS_SETUP clocks after cs_n falls.
   assign gen_en   = ((state_reg == SETUP) && tmr_zero) ||
                     ((state_reg == SHIFT) && (bit_cnt_reg != BIT_W'(FRAME_BITS)));

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk       (clk),
      .srst      (reset),
      .en        (gen_en),
      .cpol      (CPOL),
      .sclk      (sclk),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
         assign spi_clk[gi] = (cur_sel_reg == SEL_W'(gi)) ? sclk : CPOL;
         assign cs_n[gi]    = cs_n_reg[gi];
      end
   endgenerate

   assign busy        = busy_reg;
   assign data_valid  = data_valid_reg;
   assign sweep_done  = sweep_done_reg;
   assign slave_sel   = slave_sel_reg;
   assign sin_index   = sin_index_reg;
   assign uart_id     = uart_id_reg;
   assign id_mismatch = id_mismatch_reg;

   // Descending scan so the lowest set bit is the final assignment.
   always_comb begin
      lowest_sel = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (mask_reg[i]) lowest_sel = SEL_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_transfer) state_next = SCAN;
         SCAN:    state_next = (mask_reg == '0) ? IDLE : SETUP;
         SETUP:   if (tmr_zero) state_next = SHIFT;
         SHIFT:   if (tmr_zero) state_next = HOLD;
         HOLD:    if (tmr_zero) state_next = PUBLISH;
         PUBLISH: state_next = SCAN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_reg        <= '0;
         cur_sel_reg     <= '0;
         tmr_reg         <= '0;
         bit_cnt_reg     <= '0;
         shreg_reg       <= '0;
         cs_n_reg        <= '1;
         busy_reg        <= 1'b0;
         data_valid_reg  <= 1'b0;
         sweep_done_reg  <= 1'b0;
         slave_sel_reg   <= '0;
         sin_index_reg   <= '0;
         uart_id_reg     <= '0;
         id_mismatch_reg <= 1'b0;
      end else begin
         data_valid_reg <= 1'b0;
         sweep_done_reg <= 1'b0;
         if (lead_stb)  shreg_reg   <= {shreg_reg[FRAME_BITS-2:0], miso[cur_sel_reg]};
         if (trail_stb) bit_cnt_reg <= bit_cnt_reg + 1'b1;
         case (state_reg)
            IDLE: begin
               if (start_transfer) begin
                  mask_reg <= slave_en;
                  busy_reg <= 1'b1;
               end
            end
            SCAN: begin
               if (mask_reg == '0) begin
                  sweep_done_reg <= 1'b1;
                  busy_reg       <= 1'b0;
               end else begin
                  cur_sel_reg <= lowest_sel;
                  cs_n_reg    <= ~(N_SLAVES'(1) << lowest_sel);
                  tmr_reg     <= TMR_W'(CS_SETUP - 1);
                  bit_cnt_reg <= '0;
               end
            end
            SETUP:   tmr_reg <= tmr_zero ? TMR_W'(SHIFT_CYC - 1) : tmr_reg - 1'b1;
            SHIFT:   tmr_reg <= tmr_zero ? TMR_W'(CS_HOLD - 1) : tmr_reg - 1'b1;
            HOLD: begin
               if (tmr_zero) cs_n_reg <= '1;
               else          tmr_reg  <= tmr_reg - 1'b1;
            end
            PUBLISH: begin
               sin_index_reg         <= shreg_reg[FRAME_BITS-1:ID_BITS];
               uart_id_reg           <= shreg_reg[ID_BITS-1:0];
               slave_sel_reg         <= cur_sel_reg;
               id_mismatch_reg       <= 32'(shreg_reg[ID_BITS-1:0]) != 32'(cur_sel_reg);
               data_valid_reg        <= 1'b1;
               mask_reg[cur_sel_reg] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_multi_request_data.sv
// Bench for spi_multi_request_data: per-slave SPI models, a frame-list reference model,
// an SCLK/cs_n protocol monitor, directed table sweeps, random sweeps and a mid-frame reset.
module tb_spi_multi_request_data;

   localparam int N   = 3;
   localparam int FB  = 16;
   localparam int DIV = 2;
   localparam int SU  = 2;
   localparam int HD  = 2;
   localparam int LAT = SU + 2 * DIV * FB + HD + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_transfer = 1'b0;
   logic [2:0]  slave_en = 3'b000;
   logic [2:0]  miso = 3'b000;
   logic [2:0]  spi_clk, cs_n;
   logic        busy, data_valid, id_mismatch, sweep_done;
   logic [1:0]  slave_sel;
   logic [11:0] sin_index;
   logic [3:0]  uart_id;

   spi_multi_request_data #(
      .N_SLAVES(N), .INDEX_BITS(12), .ID_BITS(4), .CLK_DIV(DIV),
      .CS_SETUP(SU), .CS_HOLD(HD), .CPOL(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .start_transfer(start_transfer), .slave_en(slave_en),
      .miso(miso), .spi_clk(spi_clk), .cs_n(cs_n), .busy(busy), .data_valid(data_valid),
      .slave_sel(slave_sel), .sin_index(sin_index), .uart_id(uart_id),
      .id_mismatch(id_mismatch), .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave model: MSB driven at cs_n fall, next bit after each falling SCLK.
   logic [15:0] slave_word [3];
   logic [15:0] sr [3] = '{default: 16'h0};
   logic [2:0]  prev_cs_m = 3'b111;
   logic [2:0]  prev_sck_m = 3'b000;
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (prev_cs_m[i] && !cs_n[i])                          sr[i] = slave_word[i];
         else if (!cs_n[i] && prev_sck_m[i] && !spi_clk[i])     sr[i] = sr[i] << 1;
         miso[i] = sr[i][15];
      end
      prev_cs_m  = cs_n;
      prev_sck_m = spi_clk;
   end

   // Protocol monitor: SCLK half periods, edge counts, no SCLK activity without cs_n, one cs_n low.
   int   viol = 0;
   int   falls [3] = '{default: 0};
   int   rises [3] = '{default: 0};
   int   run_len [3] = '{default: 0};
   int   cs_fall_cyc = 0;
   bit   mon_en = 1'b1;
   logic [2:0] prev_cs = 3'b111;
   logic [2:0] prev_sck = 3'b000;
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (prev_cs[i] && !cs_n[i]) begin
            falls[i]++;
            rises[i]   = 0;
            run_len[i] = 1;
            cs_fall_cyc = cyc;
         end else if (!cs_n[i]) begin
            if (spi_clk[i] !== prev_sck[i]) begin
               if (spi_clk[i]) begin
                  if (run_len[i] != ((rises[i] == 0) ? SU : DIV)) viol++;
                  rises[i]++;
               end else if (run_len[i] != DIV) viol++;
               run_len[i] = 1;
            end else run_len[i]++;
         end
         if (mon_en && !prev_cs[i] && cs_n[i] && rises[i] != FB) viol++;
         if (mon_en && cs_n[i] && spi_clk[i] !== prev_sck[i]) viol++;
      end
      if (mon_en && $countones(~cs_n) > 1) viol++;
      prev_cs  = cs_n;
      prev_sck = spi_clk;
   end

   typedef struct {
      int sel;
      int idx;
      int id;
      bit mis;
   } frame_t;

   typedef struct {
      logic [2:0]       en;
      logic [2:0][15:0] w;
      int               repulse;
      int               exp_frames;
      int               exp_mism;
   } vec_t;

   task automatic reset_checks(input string tag);
      check({tag, "_cs_n"}, cs_n, 3'b111);
      check({tag, "_spi_clk"}, spi_clk, 3'b000);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_data_valid"}, data_valid, 0);
      check({tag, "_sweep_done"}, sweep_done, 0);
      check({tag, "_slave_sel"}, slave_sel, 0);
      check({tag, "_sin_index"}, sin_index, 0);
      check({tag, "_uart_id"}, uart_id, 0);
      check({tag, "_id_mismatch"}, id_mismatch, 0);
   endtask

   task automatic run_sweep(input logic [2:0] en, input logic [2:0][15:0] w, input int repulse,
                            input int exp_frames, input int exp_mism, input int tag);
      frame_t exp_q[$];
      frame_t f;
      int     nfr, nmis, dv_cyc, start_cyc, busy_err, idle_err;
      int     fall0 [3];
      bit     done;
      nfr = 0; nmis = 0; dv_cyc = 0; busy_err = 0; idle_err = 0; done = 1'b0;
      for (int i = 0; i < N; i++) begin
         slave_word[i] = w[i];
         fall0[i] = falls[i];
         if (en[i]) begin
            f.sel = i;
            f.idx = int'(w[i]) / 16;
            f.id  = int'(w[i]) % 16;
            f.mis = (f.id != i);
            exp_q.push_back(f);
         end
      end
      slave_en = en;
      start_transfer = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start_transfer = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
         if (data_valid) begin
            nfr++;
            if (id_mismatch) nmis++;
            $display("sweep %0d frame sel=%0d sin_index=%h uart_id=%h id_mismatch=%b cycle=%0d",
                     tag, slave_sel, sin_index, uart_id, id_mismatch, cyc);
            if (exp_q.size() > 0) begin
               f = exp_q.pop_front();
               check("slave_sel", slave_sel, f.sel);
               check("sin_index", sin_index, f.idx);
               check("uart_id", uart_id, f.id);
               check("id_mismatch", id_mismatch, f.mis);
               check("latency", cyc - cs_fall_cyc, LAT);
            end
            dv_cyc = cyc;
         end
         if (sweep_done) begin
            done = 1'b1;
            check("busy_at_done", busy, 0);
            if (nfr > 0) check("done_after_last_dv", cyc - dv_cyc, 1);
            else         check("done_after_start", cyc - start_cyc, 2);
         end else if (busy !== 1'b1) busy_err++;
         if (!done) begin
            start_transfer = (k == repulse);
            if (k == repulse) slave_en = ~en;
            @(negedge clk);
         end
      end
      start_transfer = 1'b0;
      check("sweep_completed", done, 1);
      check("frame_count", nfr, exp_frames);
      check("mismatch_count", nmis, exp_mism);
      check("model_frames_left", exp_q.size(), 0);
      check("busy_during_sweep", busy_err, 0);
      for (int i = 0; i < N; i++) check("cs_n_falls", falls[i] - fall0[i], en[i]);
      repeat (20) begin
         @(negedge clk);
         if (data_valid || sweep_done || busy) idle_err++;
      end
      check("idle_after_sweep", idle_err, 0);
      $display("sweep %0d done en=%b frames=%0d mismatches=%0d", tag, en, nfr, nmis);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t             vt [6];
      logic [2:0]       ren;
      logic [2:0][15:0] rw;
      int               rm, wait_cnt;

      vt[0] = '{3'b111, {16'hFFF2, 16'h1231, 16'hABC0}, -1, 3, 0};
      vt[1] = '{3'b101, {16'h5551, 16'h1231, 16'hABC0}, -1, 2, 1};
      vt[2] = '{3'b000, {16'h1112, 16'h2221, 16'h3330}, -1, 0, 0};
      vt[3] = '{3'b111, {16'h0002, 16'h7771, 16'h0000}, 100, 3, 0};
      vt[4] = '{3'b010, {16'h0000, 16'hFFF0, 16'h0000}, -1, 1, 1};
      vt[5] = '{3'b110, {16'h1232, 16'h4561, 16'h0000}, -1, 2, 0};

      for (int i = 0; i < N; i++) slave_word[i] = 16'h0;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 6; t++)
         run_sweep(vt[t].en, vt[t].w, vt[t].repulse, vt[t].exp_frames, vt[t].exp_mism, t);

      for (int t = 0; t < 8; t++) begin
         ren = 3'($urandom_range(0, 7));
         rm = 0;
         for (int i = 0; i < N; i++) begin
            rw[i] = 16'($urandom);
            if (ren[i] && (int'(rw[i]) % 16 != i)) rm++;
         end
         run_sweep(ren, rw, -1, $countones(ren), rm, 10 + t);
      end

      // Reset in the middle of slave 1's frame.
      slave_word[0] = 16'hABC3;
      slave_word[1] = 16'h5A51;
      slave_word[2] = 16'h0F02;
      slave_en = 3'b111;
      start_transfer = 1'b1;
      @(negedge clk);
      start_transfer = 1'b0;
      wait_cnt = 0;
      while (cs_n[1] !== 1'b0 && wait_cnt < 1000) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("t6_slave1_selected", cs_n[1], 0);
      repeat (20) @(negedge clk);
      check("t6_before_reset_uart_id", uart_id, 3);
      mon_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset_checks("midreset");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      run_sweep(3'b111, {16'hFFF2, 16'h1231, 16'hABC0}, -1, 3, 0, 99);

      check("protocol_violations", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
